// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared states, serve ids and lamp encodings for the intersection sequencer
package intersection_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED     = 3'd0,
        ST_MAIN_GREEN  = 3'd1,
        ST_MAIN_YELLOW = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_PED_WALK    = 3'd5,
        ST_PED_CLEAR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        SIDE = 2'd1,
        PED  = 2'd2
    } serve_t;

    localparam logic [2:0] LAMP_RED      = 3'b100;
    localparam logic [2:0] LAMP_YELLOW   = 3'b010;
    localparam logic [2:0] LAMP_GREEN    = 3'b001;
    localparam logic [2:0] PED_DONT_WALK = 3'b100;
    localparam logic [2:0] PED_FLASH     = 3'b010;
    localparam logic [2:0] PED_WALK      = 3'b001;

    // A car head is green/yellow only in its own two states, red everywhere else.
    function automatic logic [2:0] car_lamp(input state_t s, input state_t g, input state_t y);
        if (s == g)      return LAMP_GREEN;
        else if (s == y) return LAMP_YELLOW;
        else             return LAMP_RED;
    endfunction

    function automatic logic [2:0] ped_lamp(input state_t s);
        if (s == ST_PED_WALK)       return PED_WALK;
        else if (s == ST_PED_CLEAR) return PED_FLASH;
        else                        return PED_DONT_WALK;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-enabled 8-bit phase down-counter with load and zero flag
module phase_timer #(
    parameter logic [7:0] RESET_VAL = 8'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_done
);

    logic [7:0] r_count;

    // Load beats tick; the counter parks at zero so it can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= RESET_VAL;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_tick && (r_count != 8'd0))
            r_count <= r_count - 8'd1;
    end

    assign o_done = (r_count == 8'd0);

endmodule

// File: rtl/intersection_sequencer.sv
// rtl/intersection_sequencer.sv - main/side/pedestrian traffic light sequencer with round-robin service
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int YELLOW     = 3,
    parameter int ALLRED     = 1,
    parameter int SIDE_GREEN = 6,
    parameter int WALK       = 5,
    parameter int CLEAR      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_btn,
    input  logic       side_sensor,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] ped_light,
    output logic       ped_wait
);

    if (MIN_GREEN < 1 || MIN_GREEN > 255 || YELLOW < 1 || YELLOW > 255 ||
        ALLRED < 1 || ALLRED > 255 || SIDE_GREEN < 1 || SIDE_GREEN > 255 ||
        WALK < 1 || WALK > 255 || CLEAR < 1 || CLEAR > 255) begin : g_bad_duration
        $error("intersection_sequencer: every duration parameter must lie in 1..255");
    end

    state_t     r_state;
    serve_t     r_next_srv;
    serve_t     r_last_served;
    logic       r_ped_req;
    logic       r_side_req;

    state_t     w_state_nxt;
    serve_t     w_pick;
    logic       w_done;
    logic       w_exit;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_enter_walk;
    logic       w_enter_side;

    function automatic logic [7:0] dur_m1(input state_t s);
        case (s)
            ST_MAIN_GREEN:  return 8'(MIN_GREEN - 1);
            ST_MAIN_YELLOW: return 8'(YELLOW - 1);
            ST_SIDE_GREEN:  return 8'(SIDE_GREEN - 1);
            ST_SIDE_YELLOW: return 8'(YELLOW - 1);
            ST_PED_WALK:    return 8'(WALK - 1);
            ST_PED_CLEAR:   return 8'(CLEAR - 1);
            default:        return 8'(ALLRED - 1);
        endcase
    endfunction

    // Both waiting: serve whoever did not go last.
    always_comb begin
        w_pick = r_next_srv;
        if (r_ped_req && r_side_req)
            w_pick = (r_last_served == SIDE) ? PED : SIDE;
        else if (r_ped_req)
            w_pick = PED;
        else if (r_side_req)
            w_pick = SIDE;
    end

    assign w_exit = tick && w_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ALL_RED: begin
                if (w_exit) begin
                    case (r_next_srv)
                        SIDE:    w_state_nxt = ST_SIDE_GREEN;
                        PED:     w_state_nxt = ST_PED_WALK;
                        default: w_state_nxt = ST_MAIN_GREEN;
                    endcase
                end
            end
            ST_MAIN_GREEN:  if (w_exit && (r_ped_req || r_side_req)) w_state_nxt = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: if (w_exit) w_state_nxt = ST_ALL_RED;
            ST_SIDE_GREEN:  if (w_exit) w_state_nxt = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: if (w_exit) w_state_nxt = ST_ALL_RED;
            ST_PED_WALK:    if (w_exit) w_state_nxt = ST_PED_CLEAR;
            ST_PED_CLEAR:   if (w_exit) w_state_nxt = ST_ALL_RED;
            default:        w_state_nxt = ST_ALL_RED;
        endcase
    end

    assign w_load       = (w_state_nxt != r_state);
    assign w_load_val   = dur_m1(w_state_nxt);
    assign w_enter_walk = w_load && (w_state_nxt == ST_PED_WALK);
    assign w_enter_side = w_load && (w_state_nxt == ST_SIDE_GREEN);

    phase_timer #(
        .RESET_VAL (8'(ALLRED - 1))
    ) u_phase_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_tick     (tick),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Serving a request clears it even if the input is still asserted that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_ALL_RED;
            r_next_srv    <= MAIN;
            r_last_served <= SIDE;
            r_ped_req     <= 1'b0;
            r_side_req    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_enter_walk)
                r_ped_req <= 1'b0;
            else if (ped_btn && (r_state != ST_PED_WALK) && (r_state != ST_PED_CLEAR))
                r_ped_req <= 1'b1;

            if (w_enter_side)
                r_side_req <= 1'b0;
            else if (side_sensor && (r_state != ST_SIDE_GREEN) && (r_state != ST_SIDE_YELLOW))
                r_side_req <= 1'b1;

            if (r_state == ST_MAIN_GREEN && w_load)
                r_next_srv <= w_pick;
            else if (w_enter_walk || w_enter_side)
                r_next_srv <= MAIN;

            if (w_enter_walk)
                r_last_served <= PED;
            else if (w_enter_side)
                r_last_served <= SIDE;
        end
    end

    assign main_light = car_lamp(r_state, ST_MAIN_GREEN, ST_MAIN_YELLOW);
    assign side_light = car_lamp(r_state, ST_SIDE_GREEN, ST_SIDE_YELLOW);
    assign ped_light  = ped_lamp(r_state);
    assign ped_wait   = r_ped_req;

endmodule

// File: tb/tb_intersection_sequencer.sv
// tb/tb_intersection_sequencer.sv - self-checking bench for intersection_sequencer against a phase/elapsed model
module tb_intersection_sequencer;

    localparam int MG = 4, YL = 2, AR = 1, SG = 3, WK = 3, CL = 2;
    localparam int P_AR = 0, P_MG = 1, P_MY = 2, P_SG = 3, P_SY = 4, P_PW = 5, P_PC = 6;
    localparam int S_MAIN = 0, S_SIDE = 1, S_PED = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b1;
    logic ped_btn = 1'b0;
    logic side_sensor = 1'b0;
    logic [2:0] main_light, side_light, ped_light;
    logic ped_wait;

    int n_checks = 0;
    int n_pass = 0;

    int m_phase, m_elapsed, m_next, m_last;
    bit m_ped, m_side;

    always #5 clk = ~clk;

    intersection_sequencer #(
        .MIN_GREEN (MG), .YELLOW (YL), .ALLRED (AR),
        .SIDE_GREEN (SG), .WALK (WK), .CLEAR (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .ped_btn     (ped_btn),
        .side_sensor (side_sensor),
        .main_light  (main_light),
        .side_light  (side_light),
        .ped_light   (ped_light),
        .ped_wait    (ped_wait)
    );

    function automatic int dur(input int p);
        case (p)
            P_MG: return MG;
            P_MY: return YL;
            P_SG: return SG;
            P_SY: return YL;
            P_PW: return WK;
            P_PC: return CL;
            default: return AR;
        endcase
    endfunction

    function automatic logic [9:0] m_expect();
        logic [2:0] em, es, ep;
        em = (m_phase == P_MG) ? 3'b001 : (m_phase == P_MY) ? 3'b010 : 3'b100;
        es = (m_phase == P_SG) ? 3'b001 : (m_phase == P_SY) ? 3'b010 : 3'b100;
        ep = (m_phase == P_PW) ? 3'b001 : (m_phase == P_PC) ? 3'b010 : 3'b100;
        return {em, es, ep, m_ped};
    endfunction

    function automatic logic [9:0] obs();
        return {main_light, side_light, ped_light, ped_wait};
    endfunction

    task automatic model_reset();
        m_phase = P_AR; m_elapsed = 0; m_ped = 0; m_side = 0;
        m_next = S_MAIN; m_last = S_SIDE;
    endtask

    // Each phase lasts dur() ticks counted from entry; main green waits at its end for a request.
    task automatic model_step(input bit t, input bit b, input bit s);
        int nxt;
        bit at_end, nped, nside;
        nped = m_ped; nside = m_side;
        if (b && m_phase != P_PW && m_phase != P_PC) nped = 1;
        if (s && m_phase != P_SG && m_phase != P_SY) nside = 1;
        at_end = (m_elapsed >= dur(m_phase) - 1);
        nxt = m_phase;
        if (t && at_end) begin
            case (m_phase)
                P_AR: nxt = (m_next == S_SIDE) ? P_SG : (m_next == S_PED) ? P_PW : P_MG;
                P_MG: if (m_ped || m_side) begin
                    nxt = P_MY;
                    if (m_ped && m_side) m_next = (m_last == S_PED) ? S_SIDE : S_PED;
                    else m_next = m_ped ? S_PED : S_SIDE;
                end
                P_MY: nxt = P_AR;
                P_SG: nxt = P_SY;
                P_SY: nxt = P_AR;
                P_PW: nxt = P_PC;
                default: nxt = P_AR;
            endcase
        end
        if (nxt != m_phase) begin
            m_elapsed = 0;
            if (nxt == P_PW) begin nped = 0; m_last = S_PED; m_next = S_MAIN; end
            if (nxt == P_SG) begin nside = 0; m_last = S_SIDE; m_next = S_MAIN; end
        end else if (t && !at_end) begin
            m_elapsed++;
        end
        m_phase = nxt; m_ped = nped; m_side = nside;
    endtask

    task automatic step();
        model_step(tick, ped_btn, side_sensor);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick = 1'b1; ped_btn = 1'b0; side_sensor = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ped_btn = 1'b1; side_sensor = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 10'b100_100_100_0)
            $display("FAIL reset_outputs got %b want %b", obs(), 10'b100_100_100_0);
        else n_pass++;
        ped_btn = 1'b0; side_sensor = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== 10'b100_100_100_0)
            $display("FAIL release_all_red got %b want %b", obs(), 10'b100_100_100_0);
        else n_pass++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if (obs() !== 10'b001_100_100_0 || obs() !== m_expect())
                $display("FAIL idle_main_green cycle %0d got %b want %b", i, obs(), 10'b001_100_100_0);
            else n_pass++;
        end
    endtask

    task automatic test_ped_service();
        logic [2:0] em [13];
        logic [2:0] ep [13];
        logic       ew [13];
        em = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        ep = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        step();
        n_checks++;
        if (obs() !== 10'b001_100_100_0)
            $display("FAIL ped_entry got %b want %b", obs(), 10'b001_100_100_0);
        else n_pass++;
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (obs() !== {em[i], 3'b100, ep[i], ew[i]} || obs() !== m_expect())
                $display("FAIL ped_sequence cycle %0d got %b want %b", i, obs(), {em[i], 3'b100, ep[i], ew[i]});
            else n_pass++;
            step();
        end
    endtask

    task automatic test_both_requests();
        int pw_idx, sg_idx, mg_between, sg_cnt, sy_cnt;
        pw_idx = -1; sg_idx = -1; mg_between = 0; sg_cnt = 0; sy_cnt = 0;
        do_reset();
        step();
        ped_btn = 1'b1; side_sensor = 1'b1;
        step();
        ped_btn = 1'b0; side_sensor = 1'b0;
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if (obs() !== m_expect())
                $display("FAIL both_model cycle %0d got %b want %b", i, obs(), m_expect());
            else n_pass++;
            if (ped_light == 3'b001 && pw_idx < 0) pw_idx = i;
            if (side_light == 3'b001 && sg_idx < 0) sg_idx = i;
            if (side_light == 3'b001) sg_cnt++;
            if (side_light == 3'b010) sy_cnt++;
            if (main_light == 3'b001 && pw_idx >= 0 && sg_idx < 0) mg_between++;
            step();
        end
        n_checks++;
        if (!(pw_idx >= 0 && sg_idx > pw_idx && mg_between >= 4))
            $display("FAIL both_order ped_at %0d side_at %0d main_between %0d want ped<side, main>=4", pw_idx, sg_idx, mg_between);
        else n_pass++;
        n_checks++;
        if (sg_cnt != SG || sy_cnt != YL)
            $display("FAIL both_side_lengths green %0d yellow %0d want %0d %0d", sg_cnt, sy_cnt, SG, YL);
        else n_pass++;
    endtask

    task automatic reach_walk(input string tag);
        int n;
        n = 0;
        while (ped_light !== 3'b001 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (ped_light !== 3'b001)
            $display("FAIL %s_reach_walk got %b want %b", tag, ped_light, 3'b001);
        else n_pass++;
    endtask

    task automatic test_ped_ignored();
        int bad;
        bad = 0;
        do_reset();
        step();
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        reach_walk("ignored");
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs() !== m_expect() || ped_wait !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL ped_ignored_wait bad_cycles %0d want 0", bad);
        else n_pass++;
        n_checks++;
        if (obs() !== 10'b001_100_100_0)
            $display("FAIL ped_ignored_hold got %b want %b", obs(), 10'b001_100_100_0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        reach_walk("async");
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 10'b100_100_100_0)
            $display("FAIL async_reset_immediate got %b want %b", obs(), 10'b100_100_100_0);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (obs() !== 10'b100_100_100_0)
            $display("FAIL async_release_all_red got %b want %b", obs(), 10'b100_100_100_0);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (obs() !== 10'b001_100_100_0 || obs() !== m_expect())
                $display("FAIL async_main_green cycle %0d got %b want %b", i, obs(), 10'b001_100_100_0);
            else n_pass++;
        end
    endtask

    task automatic test_tick_freeze();
        int n, bad;
        n = 0; bad = 0;
        do_reset();
        step();
        side_sensor = 1'b1;
        step();
        side_sensor = 1'b0;
        while (side_light !== 3'b001 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (side_light !== 3'b001)
            $display("FAIL freeze_reach_side got %b want %b", side_light, 3'b001);
        else n_pass++;
        step();
        tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (side_light !== 3'b001 || obs() !== m_expect()) bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL freeze_side_hold bad_cycles %0d want 0", bad);
        else n_pass++;
        tick = 1'b1;
        n = 0;
        while (side_light === 3'b001 && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 2 || side_light !== 3'b010)
            $display("FAIL freeze_resume remaining %0d light %b want 2 010", n, side_light);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad_model, bad_safe;
        logic car_busy_m, car_busy_s, ped_busy;
        bad_model = 0; bad_safe = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick        = ($urandom_range(0, 3) != 0);
            ped_btn     = ($urandom_range(0, 9) == 0);
            side_sensor = ($urandom_range(0, 7) == 0);
            step();
            if (obs() !== m_expect()) begin
                if (bad_model < 5) $display("FAIL random_model cycle %0d got %b want %b", i, obs(), m_expect());
                bad_model++;
            end
            car_busy_m = (main_light !== 3'b100);
            car_busy_s = (side_light !== 3'b100);
            ped_busy   = (ped_light !== 3'b100);
            if ((car_busy_m && car_busy_s) || (ped_busy && (car_busy_m || car_busy_s)) ||
                !$onehot(main_light) || !$onehot(side_light) || !$onehot(ped_light))
                bad_safe++;
        end
        tick = 1'b1; ped_btn = 1'b0; side_sensor = 1'b0;
        n_checks++;
        if (bad_model != 0)
            $display("FAIL random_model_total bad_cycles %0d want 0", bad_model);
        else n_pass++;
        n_checks++;
        if (bad_safe != 0)
            $display("FAIL random_safety bad_cycles %0d want 0", bad_safe);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_ped_service();
        test_both_requests();
        test_ped_ignored();
        test_async_reset();
        test_tick_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/intersection_sequencer.md
INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameters SHALL be MIN_GREEN, default 8, minimum main-road green in ticks (1..255).
REQ-002 Parameters SHALL be YELLOW, default 3, yellow duration in ticks (1..255).
REQ-003 Parameters SHALL be ALLRED, default 1, all-red clearance in ticks (1..255).
REQ-004 Parameters SHALL be SIDE_GREEN, default 6, side-road green in ticks (1..255).
REQ-005 Parameters SHALL be WALK, default 5, pedestrian walk in ticks (1..255).
REQ-006 Parameters SHALL be CLEAR, default 3, pedestrian flashing clearance in ticks (1..255).
REQ-007 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-008 Ports SHALL be: reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-009 Ports SHALL be: tick  in  1  one-cycle timing strobe; timers advance only when tick=1.
REQ-010 Ports SHALL be: ped_btn  in  1  pedestrian request, level or pulse, sampled each clk.
REQ-011 Ports SHALL be: side_sensor  in  1  side-road vehicle present, sampled each clk.
REQ-012 Ports SHALL be: main_light  out  3  {red,yellow,green}, one-hot.
REQ-013 Ports SHALL be: side_light  out  3  {red,yellow,green}, one-hot.
REQ-014 Ports SHALL be: ped_light  out  3  {dont_walk,flash,walk}, one-hot.
REQ-015 Ports SHALL be: ped_wait  out  1  pedestrian request latched, not yet served.

Function
REQ-016 States SHALL be ALL_RED, MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW, PED_WALK, PED_CLEAR.
REQ-017 On state entry, the 8-bit timer SHALL load duration-1; the state exits on the first tick with timer==0; no tick = state and timer frozen.
REQ-018 ped_req SHALL set one clk after ped_btn=1 in any state except PED_WALK/PED_CLEAR (presses there ignored); cleared on entry to PED_WALK.
REQ-019 side_req SHALL set one clk after side_sensor=1 in any state except SIDE_GREEN/SIDE_YELLOW; cleared on entry to SIDE_GREEN.
REQ-020 MAIN_GREEN SHALL persist while no request is latched; exits to MAIN_YELLOW only when MIN_GREEN ticks have elapsed and ped_req or side_req=1.
REQ-021 At MAIN_GREEN exit, the served requester SHALL be chosen and held in next_srv: single pending wins; both pending -> the one not equal to last_served (round-robin).
REQ-022 Transitions SHALL be MAIN_YELLOW->ALL_RED->(SIDE_GREEN | PED_WALK per next_srv); SIDE_GREEN->SIDE_YELLOW->ALL_RED; PED_WALK->PED_CLEAR->ALL_RED; ALL_RED after side/ped service -> MAIN_GREEN.
REQ-023 last_served SHALL update on entry to SIDE_GREEN or PED_WALK.
REQ-024 Outputs SHALL be Moore, decoded from state: main green only in MAIN_GREEN, yellow in MAIN_YELLOW, else red; side likewise; ped walk=001 in PED_WALK, flash=010 in PED_CLEAR, else 100.
REQ-025 No state SHALL ever drive green/yellow on main and side simultaneously, nor walk/flash with any non-red car light.
REQ-026 ped_wait SHALL equal ped_req.
REQ-027 Timer underflow SHALL not occur; a duration parameter of 0 is illegal and checked by a static assertion.

Reset
REQ-028 reset=0 SHALL immediately force state ALL_RED, next_srv=MAIN, last_served=SIDE, ped_req=side_req=0, timer=ALLRED-1.
REQ-029 During reset, outputs SHALL be main_light=100, side_light=100, ped_light=100, ped_wait=0; reset mid-operation abandons service and discards latched requests.
REQ-030 After reset release, ALL_RED SHALL run ALLRED ticks, then MAIN_GREEN.

Structure
REQ-031 Package intersection_pkg SHALL hold the state enum, serve enum {MAIN,SIDE,PED}, and the light one-hot constants RED=100, YELLOW=010, GREEN=001, DONT_WALK=100, FLASH=010, WALK=001.
REQ-032 One sub-module phase_timer SHALL be used: tick-enabled 8-bit down-counter with load, load value, and done (timer==0) outputs.

Verification (tick=1 every clk; MIN_GREEN=4, YELLOW=2, ALLRED=1, SIDE_GREEN=3, WALK=3, CLEAR=2)
REQ-033 Release reset, no requests -> 1 clk ALL_RED (all 100), then main_light=001, side_light=100, ped_light=100 held 50 clks.
REQ-034 1-clk ped_btn at MAIN_GREEN entry -> ped_wait=1 next clk; main 001x4, 010x2, 100; ped 001x3, 010x2; 1 clk all-red; main 001; ped_wait=0 from PED_WALK entry.
REQ-035 ped_btn and side_sensor together after reset -> PED served first (last_served=SIDE), then after >=4 clks main green, side_light 001x3, 010x2.
REQ-036 ped_btn pulsed during PED_WALK -> ignored; ped_wait stays 0; MAIN_GREEN holds afterwards.
REQ-037 reset=0 asynchronously mid-PED_WALK -> all outputs 100, ped_wait=0 before next clk edge; release -> REQ-030 sequence.
REQ-038 tick=0 for 20 clks during SIDE_GREEN -> side_light stays 001, timer unchanged; resumes remaining ticks when tick returns.
